// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_rd_arb_pkg;
  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_t;
endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Combinational round-robin pick: first requester after last_idx, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);
  int idx;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_idx) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin sharing of one AXI slave's AR/R channels among NUM_M masters, one burst per grant.
// Optional burst-length checking (len_err port) is enabled with AXI_RD_ARB_CHECK_EN.
module axi_read_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_M      = 2,
  localparam int IDX_W      = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_M*ADDR_WIDTH-1:0]   m_araddr,
  input  logic [NUM_M*AXI_LEN_W-1:0]    m_arlen,
  input  logic [NUM_M-1:0]              m_arvalid,
  output logic [NUM_M-1:0]              m_arready,
  output logic [DATA_WIDTH-1:0]         m_rdata,
  output logic                          m_rlast,
  output logic [NUM_M-1:0]              m_rvalid,
  input  logic [NUM_M-1:0]              m_rready,
  output logic [ADDR_WIDTH-1:0]         s_araddr,
  output logic [AXI_LEN_W-1:0]          s_arlen,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [DATA_WIDTH-1:0]         s_rdata,
  input  logic                          s_rlast,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
`ifdef AXI_RD_ARB_CHECK_EN
  ,
  output logic                          len_err
`endif
);
  rd_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic             ar_hs, r_hs;
`ifdef AXI_RD_ARB_CHECK_EN
  logic [AXI_LEN_W-1:0] arlen_q, arlen_d;
  logic [AXI_LEN_W:0]   beat_q, beat_d;
  logic                 len_err_q, len_err_d;
`endif

  rr_arbiter #(.N(NUM_M)) u_rr (
    .req       (m_arvalid),
    .last_idx  (last_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_vld)
  );

  assign ar_hs = (state_q == ADDR) && s_arvalid && s_arready;
  assign r_hs  = (state_q == DATA) && s_rvalid && s_rready;

  // State register; last_q resets to NUM_M-1 so master 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_M - 1);
`ifdef AXI_RD_ARB_CHECK_EN
      len_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
`ifdef AXI_RD_ARB_CHECK_EN
      len_err_q <= len_err_d;
`endif
    end
  end

`ifdef AXI_RD_ARB_CHECK_EN
  always_ff @(posedge clk) begin
    arlen_q <= arlen_d;
    beat_q  <= beat_d;
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef AXI_RD_ARB_CHECK_EN
    arlen_d   = arlen_q;
    beat_d    = beat_q;
    len_err_d = len_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
`ifdef AXI_RD_ARB_CHECK_EN
          arlen_d = s_arlen;
          beat_d  = '0;
`endif
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
`ifdef AXI_RD_ARB_CHECK_EN
          beat_d = beat_q + 1'b1;
          // Error when rlast and "this is beat arlen+1" disagree; exit still waits for rlast.
          if (s_rlast != ((beat_q + 1'b1) == ({1'b0, arlen_q} + 1'b1)))
            len_err_d = 1'b1;
`endif
          if (s_rlast) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: only the granted master sees ready/valid, and only in its phase.
  always_comb begin
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    case (state_q)
      ADDR: begin
        s_arvalid          = m_arvalid[grant_q];
        m_arready[grant_q] = s_arready;
      end
      DATA: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
      end
      default: ;
    endcase
  end

  assign s_araddr  = m_araddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_arlen   = m_arlen[int'(grant_q)*AXI_LEN_W +: AXI_LEN_W];
  assign m_rdata   = s_rdata;
  assign m_rlast   = s_rlast;
  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);
`ifdef AXI_RD_ARB_CHECK_EN
  assign len_err   = len_err_q;
`endif
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with a small cycle-stepped AXI slave model.
// Define AXI_RD_ARB_CHECK_EN to also exercise the len_err checker.
module tb_axi_read_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic        s_rlast, s_rvalid, s_rready;
  logic [0:0]  grant_idx;
  logic        busy;
`ifdef AXI_RD_ARB_CHECK_EN
  logic        len_err;
`endif

  axi_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_M(2)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_idx(grant_idx), .busy(busy)
`ifdef AXI_RD_ARB_CHECK_EN
    , .len_err(len_err)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Slave model state and per-master outstanding burst counts
  int rem [2];
  int sl_active, sl_beat, sl_len, sl_early;
  int stall, stall_en, stall_bad, rv1_seen;
  int in_gap, gap_cnt, prev_last, post_last_busy;
  logic [31:0] tab [4];

  // Observation logs
  logic [31:0] bq_data[$];
  int          bq_mst[$];
  int          bq_last[$];
  int          gq[$];
  logic [31:0] aq_addr[$];
  int          gapq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) m_arvalid[i] = (rem[i] > 0);
    m_rready  = {(stall > 0) ? 1'b0 : 1'b1, 1'b1};
    s_arready = 1'b1;
    s_rvalid  = (sl_active != 0);
    s_rdata   = (sl_beat < 4) ? tab[sl_beat] : (32'hDEAD0000 + 32'(sl_beat));
    s_rlast   = (sl_active != 0) && ((sl_beat == sl_len) || (sl_beat + 1 == sl_early));
  endtask

  task automatic clear_logs();
    bq_data.delete(); bq_mst.delete(); bq_last.delete();
    gq.delete(); aq_addr.delete(); gapq.delete();
    in_gap = 0; gap_cnt = 0; prev_last = 0; post_last_busy = -1;
    rv1_seen = 0; stall_bad = 0;
  endtask

  // One clock: observe at negedge, update slave/master stimulus just after posedge.
  task automatic tick();
    bit ar_hs, r_hs, r_last;
    int gi, alen;
    @(negedge clk);
    ar_hs  = s_arvalid && s_arready;
    r_hs   = s_rvalid && s_rready;
    r_last = s_rlast;
    gi     = int'(grant_idx);
    alen   = int'(s_arlen);
    if (m_rvalid[1]) rv1_seen++;
    if (stall > 0 && s_rready) stall_bad++;
    if (prev_last != 0) begin post_last_busy = int'(busy); prev_last = 0; end
    if (in_gap != 0) begin
      if (busy) begin gapq.push_back(gap_cnt); in_gap = 0; end
      else gap_cnt++;
    end
    if (ar_hs) begin gq.push_back(gi); aq_addr.push_back(s_araddr); end
    if (r_hs) begin
      bq_data.push_back(m_rdata);
      bq_mst.push_back((m_rvalid == 2'b01) ? 0 : (m_rvalid == 2'b10) ? 1 : 9);
      bq_last.push_back(int'(m_rlast));
      if (m_rlast) begin in_gap = 1; gap_cnt = 0; prev_last = 1; end
    end
    @(posedge clk);
    #1;
    if (stall > 0) stall--;
    if (ar_hs) begin
      rem[gi]--; sl_active = 1; sl_len = alen; sl_beat = 0;
    end else if (r_hs) begin
      if (r_last) sl_active = 0;
      else sl_beat++;
      if (stall_en != 0 && bq_data.size() == 1) stall = 2;
    end
    drive();
  endtask

  task automatic run(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      if (rem[0] == 0 && rem[1] == 0 && !busy && sl_active == 0) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done"}, done, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rem[0] = 0; rem[1] = 0;
    sl_active = 0; sl_beat = 0; sl_len = 0; sl_early = 0;
    stall = 0; stall_en = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_logs();
  endtask

  initial begin
    tab[0] = 32'hA5A5A5A5; tab[1] = 32'h5A5A5A5A;
    tab[2] = 32'h12345678; tab[3] = 32'h87654321;
    m_araddr = {32'h0000_1000, 32'h0000_0000};
    m_arlen  = 16'h0;
    stall = 0; stall_en = 0; sl_early = 0;
    clear_logs();

    // Reset state with requests and slave valid active
    rst = 1'b1;
    rem[0] = 1; rem[1] = 1; sl_active = 1; sl_beat = 0; sl_len = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_grant", grant_idx, 1'b0);
    check_eq("rst_s_arvalid", s_arvalid, 1'b0);
    check_eq("rst_s_rready", s_rready, 1'b0);
    check_eq("rst_m_arready", m_arready, 2'b00);
    check_eq("rst_m_rvalid", m_rvalid, 2'b00);
    do_reset();

    // 1: master 0 alone, arlen=3
    m_arlen = {8'd0, 8'd3};
    rem[0] = 1; drive();
    run("t1", 40);
    check_eq("t1_grant", gq.size() > 0 ? gq[0] : 99, 0);
    check_eq("t1_addr", aq_addr.size() > 0 ? aq_addr[0] : 32'hFFFFFFFF, 32'h0);
    check_eq("t1_nbeats", bq_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_data%0d", i), bq_data[i], tab[i]);
      check_eq($sformatf("t1_mst%0d", i), bq_mst[i], 0);
      check_eq($sformatf("t1_last%0d", i), bq_last[i], (i == 3) ? 1 : 0);
    end
    check_eq("t1_rv1_quiet", rv1_seen, 0);

    // 2: both masters continuously, 3 bursts each, arlen=1
    do_reset();
    m_arlen = {8'd1, 8'd1};
    rem[0] = 3; rem[1] = 3; drive();
    run("t2", 200);
    check_eq("t2_ngrants", gq.size(), 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("t2_order%0d", i), gq[i], i % 2);
    check_eq("t2_nbeats", bq_data.size(), 12);
    check_eq("t2_ngaps", gapq.size(), 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t2_gap%0d", i), gapq[i], 1);

    // 3: master 1, arlen=3, m_rready[1] low for 2 cycles after beat 1
    do_reset();
    m_arlen = {8'd3, 8'd0};
    stall_en = 1;
    rem[1] = 1; drive();
    run("t3", 40);
    check_eq("t3_grant", gq.size() > 0 ? gq[0] : 99, 1);
    check_eq("t3_addr", aq_addr.size() > 0 ? aq_addr[0] : 32'hFFFFFFFF, 32'h1000);
    check_eq("t3_nbeats", bq_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_data%0d", i), bq_data[i], tab[i]);
      check_eq($sformatf("t3_mst%0d", i), bq_mst[i], 1);
    end
    check_eq("t3_last", bq_last[3], 1);
    check_eq("t3_stall_rready", stall_bad, 0);

    // 4: reset during beat 2 of a burst, then simultaneous requests
    do_reset();
    m_arlen = {8'd3, 8'd3};
    rem[0] = 1; drive();
    for (int c = 0; c < 20 && bq_data.size() < 1; c++) tick();
    check_eq("t4_mid_busy", busy, 1'b1);
    check_eq("t4_mid_svalid", s_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t4_rst_busy", busy, 1'b0);
    check_eq("t4_rst_s_rready", s_rready, 1'b0);
    check_eq("t4_rst_m_rvalid", m_rvalid, 2'b00);
    do_reset();
    m_arlen = {8'd1, 8'd1};
    rem[0] = 1; rem[1] = 1; drive();
    run("t4", 60);
    check_eq("t4_ngrants", gq.size(), 2);
    check_eq("t4_first", gq[0], 0);
    check_eq("t4_second", gq[1], 1);

    // 5: master 1, arlen=0
    do_reset();
    m_arlen = {8'd0, 8'd0};
    rem[1] = 1; drive();
    run("t5", 20);
    tick();
    check_eq("t5_nbeats", bq_data.size(), 1);
    check_eq("t5_last", bq_last[0], 1);
    check_eq("t5_mst", bq_mst[0], 1);
    check_eq("t5_busy_after", post_last_busy, 0);

`ifdef AXI_RD_ARB_CHECK_EN
    // 6: arlen=3 but slave ends the burst on beat 2
    do_reset();
    check_eq("t6_err_init", len_err, 1'b0);
    m_arlen = {8'd0, 8'd3};
    sl_early = 2;
    rem[0] = 1; drive();
    run("t6", 40);
    check_eq("t6_nbeats", bq_data.size(), 2);
    check_eq("t6_last", bq_last[1], 1);
    check_eq("t6_err", len_err, 1'b1);
    check_eq("t6_idle", busy, 1'b0);
    repeat (3) tick();
    check_eq("t6_err_sticky", len_err, 1'b1);
    do_reset();
    check_eq("t6_err_cleared", len_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
